// File: rtl/mpeg_mv_pkg.sv
// rtl/mpeg_mv_pkg.sv - shared constants, FSM states and LUT result type for motion-vector decode
package mpeg_mv_pkg;

  localparam int         MV_W         = 13;
  localparam int         MAX_FCODE    = 9;
  localparam logic [4:0] MVCODE_ERROR = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_RES,
    ST_CALC,
    ST_OUT,
    ST_ERR
  } mv_state_e;

  typedef struct packed {
    logic [4:0] magnitude;
    logic [4:0] length;
    logic       error;
  } mv_lut_t;

  function automatic mv_lut_t mv_lut_entry(input logic [4:0] mag, input logic [4:0] len);
    return '{magnitude: mag, length: len, error: 1'b0};
  endfunction

endpackage

// File: rtl/mv_decode_ctrl_if.sv
// rtl/mv_decode_ctrl_if.sv - bitstream peek/flush port and reconstructed-vector valid/ready port
interface mv_decode_ctrl_if #(
  parameter int MV_W = mpeg_mv_pkg::MV_W
);

  logic [19:0]            bs_bits;
  logic                   bs_valid;
  logic                   bs_flush;
  logic [4:0]             bs_flush_len;
  logic signed [MV_W-1:0] mv_h;
  logic signed [MV_W-1:0] mv_v;
  logic                   mv_valid;
  logic                   mv_ready;

  modport master (
    input  bs_bits, bs_valid, mv_ready,
    output bs_flush, bs_flush_len, mv_h, mv_v, mv_valid
  );

  modport slave (
    output bs_bits, bs_valid, mv_ready,
    input  bs_flush, bs_flush_len, mv_h, mv_v, mv_valid
  );

endinterface

// File: rtl/mv_vlc_lut.sv
// rtl/mv_vlc_lut.sv - combinational motion_code VLC table; length includes the trailing sign bit
module mv_vlc_lut
  import mpeg_mv_pkg::*;
(
  input  logic [10:0] code_bits,
  output mv_lut_t     res
);

  // Short codes, 0000_1xx/0000_011 mid range, 0000_01x/0000_0011 long range; the rest is invalid
  always_comb begin
    res = '{magnitude: MVCODE_ERROR, length: 5'd0, error: 1'b1};
    casez (code_bits)
      11'b1??????????: res = mv_lut_entry(5'd0,  5'd1);
      11'b01?????????: res = mv_lut_entry(5'd1,  5'd3);
      11'b001????????: res = mv_lut_entry(5'd2,  5'd4);
      11'b0001???????: res = mv_lut_entry(5'd3,  5'd5);
      11'b000011?????: res = mv_lut_entry(5'd4,  5'd7);
      11'b0000101????: res = mv_lut_entry(5'd5,  5'd8);
      11'b0000100????: res = mv_lut_entry(5'd6,  5'd8);
      11'b0000011????: res = mv_lut_entry(5'd7,  5'd8);
      11'b000001011??: res = mv_lut_entry(5'd8,  5'd10);
      11'b000001010??: res = mv_lut_entry(5'd9,  5'd10);
      11'b000001001??: res = mv_lut_entry(5'd10, 5'd10);
      11'b0000010001?: res = mv_lut_entry(5'd11, 5'd11);
      11'b0000010000?: res = mv_lut_entry(5'd12, 5'd11);
      11'b0000001111?: res = mv_lut_entry(5'd13, 5'd11);
      11'b0000001110?: res = mv_lut_entry(5'd14, 5'd11);
      11'b0000001101?: res = mv_lut_entry(5'd15, 5'd11);
      11'b0000001100?: res = mv_lut_entry(5'd16, 5'd11);
      default:         res = '{magnitude: MVCODE_ERROR, length: 5'd0, error: 1'b1};
    endcase
  end

endmodule

// File: rtl/mv_decode_ctrl.sv
// rtl/mv_decode_ctrl.sv - motion-vector decode sequencer: VLC, residual, reconstruction with wrap
module mv_decode_ctrl #(
  parameter int MV_W      = mpeg_mv_pkg::MV_W,
  parameter int MAX_FCODE = mpeg_mv_pkg::MAX_FCODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             f_code_h,
  input  logic [3:0]             f_code_v,
  input  logic signed [MV_W-1:0] pmv_h,
  input  logic signed [MV_W-1:0] pmv_v,
  mv_decode_ctrl_if.master       bus,
  output logic                   busy,
  output logic                   err
);
  import mpeg_mv_pkg::*;

  // Headroom so 32<<r_size and the pre-wrap sum never overflow
  localparam int CW = MV_W + 3;

  mv_state_e              state_q, state_d;
  logic                   comp_q, comp_d;
  logic [3:0]             rsize_h_q, rsize_v_q, rsize;
  logic signed [MV_W-1:0] pmv_h_q, pmv_v_q, mv_h_q, mv_v_q;
  logic [4:0]             mag_q;
  logic                   sign_q;
  logic [7:0]             res_q, res_win;
  logic                   flushed_q, win_ok, flush;
  logic [4:0]             flush_len;
  logic                   bad_fcode, code_sign;
  logic [10:0]            sign_mask;
  mv_lut_t                lut;
  logic signed [CW-1:0]   pmv_sel, delta, sum, span, mv_new;

  mv_vlc_lut u_lut (
    .code_bits (bus.bs_bits[19:9]),
    .res       (lut)
  );

  assign rsize     = comp_q ? rsize_v_q : rsize_h_q;
  // The shifter needs a cycle to present the new window after a flush
  assign win_ok    = bus.bs_valid && !flushed_q;
  assign bad_fcode = (f_code_h == 4'd0) || (f_code_v == 4'd0) ||
                     (int'(f_code_h) > MAX_FCODE) || (int'(f_code_v) > MAX_FCODE);
  assign sign_mask = 11'h400 >> (lut.length - 5'd1);
  assign code_sign = |(bus.bs_bits[19:9] & sign_mask);
  assign res_win   = bus.bs_bits[19:12] >> (4'd8 - rsize);

  always_comb begin
    state_d   = state_q;
    comp_d    = comp_q;
    flush     = 1'b0;
    flush_len = 5'd0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          comp_d  = 1'b0;
          state_d = bad_fcode ? ST_ERR : ST_CODE;
        end
      end
      ST_CODE: begin
        if (win_ok) begin
          if (lut.error) begin
            state_d = ST_ERR;
          end else begin
            flush     = 1'b1;
            flush_len = lut.length;
            state_d   = (lut.magnitude != 5'd0 && rsize != 4'd0) ? ST_RES : ST_CALC;
          end
        end
      end
      ST_RES: begin
        if (win_ok) begin
          flush     = 1'b1;
          flush_len = {1'b0, rsize};
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        if (!comp_q) begin
          comp_d  = 1'b1;
          state_d = ST_CODE;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.mv_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pmv_sel = comp_q ? CW'(pmv_v_q) : CW'(pmv_h_q);
    span    = CW'(16) <<< rsize;
    delta   = '0;
    if (mag_q != 5'd0) begin
      delta = ((CW'(mag_q) - CW'(1)) <<< rsize) + CW'(res_q) + CW'(1);
      if (sign_q) delta = -delta;
    end
    sum    = pmv_sel + delta;
    mv_new = sum;
    if (sum < -span)               mv_new = sum + (span <<< 1);
    else if (sum > span - CW'(1))  mv_new = sum - (span <<< 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      comp_q    <= 1'b0;
      rsize_h_q <= '0;
      rsize_v_q <= '0;
      pmv_h_q   <= '0;
      pmv_v_q   <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      res_q     <= '0;
      mv_h_q    <= '0;
      mv_v_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      comp_q    <= comp_d;
      flushed_q <= flush;
      if ((state_q == ST_IDLE || state_q == ST_ERR) && start) begin
        rsize_h_q <= f_code_h - 4'd1;
        rsize_v_q <= f_code_v - 4'd1;
        pmv_h_q   <= pmv_h;
        pmv_v_q   <= pmv_v;
      end
      if (state_q == ST_CODE && win_ok && !lut.error) begin
        mag_q  <= lut.magnitude;
        sign_q <= code_sign;
        res_q  <= '0;
      end
      if (state_q == ST_RES && win_ok) res_q <= res_win;
      if (state_q == ST_CALC) begin
        if (comp_q) mv_v_q <= mv_new[MV_W-1:0];
        else        mv_h_q <= mv_new[MV_W-1:0];
      end
    end
  end

  assign bus.bs_flush     = flush;
  assign bus.bs_flush_len = flush_len;
  assign bus.mv_h         = mv_h_q;
  assign bus.mv_v         = mv_v_q;
  assign bus.mv_valid     = (state_q == ST_OUT);
  assign busy             = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign err              = (state_q == ST_ERR);

  logic unused_ok;
  assign unused_ok = ^{bus.bs_bits[8:0], mv_new[CW-1:MV_W]};

endmodule

// File: tb/tb_mv_decode_ctrl.sv
// tb/tb_mv_decode_ctrl.sv - bit-queue shifter model, directed and random vectors against an arithmetic reference
module tb_mv_decode_ctrl;
  import mpeg_mv_pkg::*;

  localparam int W = 13;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [3:0]          f_code_h = 4'd1;
  logic [3:0]          f_code_v = 4'd1;
  logic signed [W-1:0] pmv_h = '0;
  logic signed [W-1:0] pmv_v = '0;
  logic                busy, err;

  mv_decode_ctrl_if #(.MV_W(W)) bus ();

  mv_decode_ctrl #(.MV_W(W), .MAX_FCODE(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .f_code_h (f_code_h),
    .f_code_v (f_code_v),
    .pmv_h    (pmv_h),
    .pmv_v    (pmv_v),
    .bus      (bus),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit bitq[$];
  int exp_len[$], obs_len[$], obs_cyc[$], exp_cyc[$];
  int cyc, vcyc;
  bit got_mv, rand_valid, rand_ready;
  logic signed [W-1:0] got_h, got_v;

  // Motion-code prefixes (sign bit excluded), indexed by magnitude
  int vlc_pat [17] = '{1, 1, 1, 1, 3, 5, 4, 3, 11, 10, 9, 17, 16, 15, 14, 13, 12};
  int vlc_n   [17] = '{1, 2, 3, 4, 6, 7, 7, 7, 9, 9, 9, 10, 10, 10, 10, 10, 10};

  task automatic check_val(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int recon(int pmv, int code, int r, int res);
    int f, mag, delta, s;
    f     = 1 << r;
    mag   = (code < 0) ? -code : code;
    delta = (mag == 0) ? 0 : (mag - 1) * f + res + 1;
    if (code < 0) delta = -delta;
    s = pmv + delta;
    if (s < -16 * f)         s = s + 32 * f;
    else if (s > 16 * f - 1) s = s - 32 * f;
    return s;
  endfunction

  task automatic refresh();
    logic [19:0] w;
    w = '0;
    for (int i = 0; i < 20; i++)
      if (i < bitq.size()) w[19-i] = bitq[i];
    bus.bs_bits = w;
  endtask

  task automatic push_bits(int val, int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(val[i]);
  endtask

  task automatic enc(int code, int r, int res);
    int m;
    m = (code < 0) ? -code : code;
    push_bits(vlc_pat[m], vlc_n[m]);
    if (m != 0) begin
      push_bits((code < 0) ? 1 : 0, 1);
      exp_len.push_back(vlc_n[m] + 1);
      if (r > 0) begin
        push_bits(res, r);
        exp_len.push_back(r);
      end
    end else begin
      exp_len.push_back(1);
    end
  endtask

  // One clock: sample DUT decisions mid-cycle, then advance the shifter after the edge
  task automatic step();
    int pop_n;
    @(negedge clk);
    pop_n = 0;
    if (bus.bs_flush) begin
      obs_len.push_back(int'(bus.bs_flush_len));
      obs_cyc.push_back(cyc);
      pop_n = int'(bus.bs_flush_len);
    end
    if (bus.mv_valid && vcyc < 0) vcyc = cyc;
    if (bus.mv_valid && bus.mv_ready) begin
      got_mv = 1'b1;
      got_h  = bus.mv_h;
      got_v  = bus.mv_v;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < pop_n; i++)
      if (bitq.size() > 0) void'(bitq.pop_front());
    refresh();
    start = 1'b0;
    cyc++;
    if (rand_valid) bus.bs_valid = ($urandom_range(0, 3) != 0);
    if (rand_ready) bus.mv_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic clear_obs();
    exp_len.delete();
    obs_len.delete();
    obs_cyc.delete();
    vcyc   = -1;
    got_mv = 1'b0;
    cyc    = 0;
  endtask

  task automatic run_vec(string tag, int fh, int fv, int ph, int pv, int ch, int cv, int rh, int rv);
    int eh, ev;
    clear_obs();
    enc(ch, fh - 1, rh);
    enc(cv, fv - 1, rv);
    refresh();
    eh = recon(ph, ch, fh - 1, rh);
    ev = recon(pv, cv, fv - 1, rv);
    f_code_h = 4'(fh);
    f_code_v = 4'(fv);
    pmv_h    = W'(ph);
    pmv_v    = W'(pv);
    start    = 1'b1;
    step();
    for (int k = 0; k < 300 && !got_mv; k++) step();
    check_val({tag, "_done"}, int'(got_mv), 1);
    check_val({tag, "_mv_h"}, int'(got_h), eh);
    check_val({tag, "_mv_v"}, int'(got_v), ev);
    check_val({tag, "_nflush"}, obs_len.size(), exp_len.size());
    for (int i = 0; i < obs_len.size() && i < exp_len.size(); i++)
      check_val($sformatf("%s_flen%0d", tag, i), obs_len[i], exp_len[i]);
    check_val({tag, "_bits_left"}, bitq.size(), 0);
  endtask

  task automatic check_timing(string tag, int vc);
    check_val({tag, "_nfl"}, obs_cyc.size(), exp_cyc.size());
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++)
      check_val($sformatf("%s_flcyc%0d", tag, i), obs_cyc[i], exp_cyc[i]);
    check_val({tag, "_vcyc"}, vcyc, vc);
  endtask

  initial begin
    int fh, fv, ph, pv, ch, cv, rh, rv, frh, frv;
    bus.bs_bits  = '0;
    bus.bs_valid = 1'b0;
    bus.mv_ready = 1'b1;
    rand_valid   = 1'b0;
    rand_ready   = 1'b0;
    cyc          = 0;
    vcyc         = -1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_flush", int'(bus.bs_flush), 0);
    check_val("rst_flen", int'(bus.bs_flush_len), 0);
    check_val("rst_valid", int'(bus.mv_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_mv_h", int'(bus.mv_h), 0);
    check_val("rst_mv_v", int'(bus.mv_v), 0);
    rst_n = 1'b1;
    bus.bs_valid = 1'b1;
    step();

    run_vec("zero", 1, 1, 0, 0, 0, 0, 0, 0);
    exp_cyc = '{1, 3};
    check_timing("zero", 5);
    run_vec("unit", 1, 1, 5, -3, 1, -1, 0, 0);
    exp_cyc = '{1, 3};
    check_timing("unit", 5);
    run_vec("wrap", 2, 1, 30, 7, 2, 0, 1, 0);
    exp_cyc = '{1, 3, 5};
    check_timing("wrap", 7);
    run_vec("tworeso", 2, 2, 0, 0, 1, -3, 1, 0);
    exp_cyc = '{1, 3, 5, 7};
    check_timing("tworeso", 9);
    run_vec("negwrap", 1, 1, -16, 15, -1, 1, 0, 0);

    // Invalid prefix: all-zero window
    clear_obs();
    bitq.delete();
    refresh();
    f_code_h = 4'd1;
    f_code_v = 4'd1;
    start = 1'b1;
    step();
    check_val("e0_busy", int'(busy), 1);
    step();
    check_val("e0_err", int'(err), 1);
    check_val("e0_busy_lo", int'(busy), 0);
    check_val("e0_valid", int'(bus.mv_valid), 0);
    repeat (3) step();
    check_val("e0_nflush", obs_len.size(), 0);
    check_val("e0_err_held", int'(err), 1);
    run_vec("clr", 1, 1, 2, 2, 3, -4, 0, 0);
    check_val("clr_err", int'(err), 0);

    f_code_h = 4'd1;
    f_code_v = 4'd0;
    start = 1'b1;
    step();
    check_val("fv0_err", int'(err), 1);
    check_val("fv0_busy", int'(busy), 0);
    run_vec("fmax", 9, 9, -4096, 4095, 16, -16, 255, 0);
    check_val("fmax_err", int'(err), 0);
    f_code_h = 4'd10;
    f_code_v = 4'd1;
    start = 1'b1;
    step();
    check_val("fh10_err", int'(err), 1);

    rand_valid = 1'b1;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      fh  = int'($urandom_range(1, 9));
      fv  = int'($urandom_range(1, 9));
      frh = 1 << (fh - 1);
      frv = 1 << (fv - 1);
      ph  = int'($urandom_range(0, 32 * frh - 1)) - 16 * frh;
      pv  = int'($urandom_range(0, 32 * frv - 1)) - 16 * frv;
      ch  = int'($urandom_range(0, 32)) - 16;
      cv  = int'($urandom_range(0, 32)) - 16;
      rh  = int'($urandom_range(0, frh - 1));
      rv  = int'($urandom_range(0, frv - 1));
      run_vec($sformatf("rnd%0d", n), fh, fv, ph, pv, ch, cv, rh, rv);
    end
    rand_valid   = 1'b0;
    rand_ready   = 1'b0;
    bus.bs_valid = 1'b1;

    // Backpressure: hold the vector, ignore start during OUT and on the accepting cycle
    clear_obs();
    bus.mv_ready = 1'b0;
    enc(3, 0, 0);
    enc(-2, 0, 0);
    refresh();
    f_code_h = 4'd1;
    f_code_v = 4'd1;
    pmv_h = '0;
    pmv_v = '0;
    start = 1'b1;
    step();
    for (int k = 0; k < 50 && !bus.mv_valid; k++) step();
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("bp_valid%0d", i), int'(bus.mv_valid), 1);
      check_val($sformatf("bp_h%0d", i), int'(bus.mv_h), recon(0, 3, 0, 0));
      check_val($sformatf("bp_v%0d", i), int'(bus.mv_v), recon(0, -2, 0, 0));
      if (i == 3) begin
        f_code_h = 4'd0;
        start = 1'b1;
      end
      step();
    end
    check_val("bp_busy", int'(busy), 1);
    bus.mv_ready = 1'b1;
    start = 1'b1;
    step();
    check_val("bp_got", int'(got_mv), 1);
    check_val("bp_idle_busy", int'(busy), 0);
    check_val("bp_idle_err", int'(err), 0);
    check_val("bp_idle_valid", int'(bus.mv_valid), 0);
    f_code_h = 4'd1;

    // Reset during the RES stall
    clear_obs();
    enc(2, 1, 1);
    enc(0, 0, 0);
    refresh();
    f_code_h = 4'd2;
    f_code_v = 4'd1;
    start = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("ar_flush", int'(bus.bs_flush), 0);
    check_val("ar_flen", int'(bus.bs_flush_len), 0);
    check_val("ar_busy", int'(busy), 0);
    check_val("ar_err", int'(err), 0);
    check_val("ar_valid", int'(bus.mv_valid), 0);
    check_val("ar_mv_h", int'(bus.mv_h), 0);
    check_val("ar_mv_v", int'(bus.mv_v), 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check_val("ar_nflush", obs_len.size(), 1);
    check_val("ar_bits_left", bitq.size(), 2);
    check_val("ar_idle_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
